keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Matrix-keypad front end for the lock datapath. Scans a 4-row × 3-column keypad and synchronises and debounces the column returns. Emits one 4-bit key code plus a one-cycle `key_valid` strobe per physical press. It sits directly upstream of the lock sequence FSM and drives its `key` input; that FSM advances only on `key_valid`.

## Interface
- `SCAN_DIV`, default 8: clock cycles each row is driven during scanning (≥2).
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required to accept a press or a release (≥1).

- `clk`  input  1  system clock, all logic on rising edge.
- `reset`  input  1  one clock; reset is synchronous and active-high.
- `col_n`  input  3  column returns, active-low, asynchronous to `clk` (pull-ups on board).
- `row_n`  output  4  row drive, active-low one-hot.
- `key`  output  4  last accepted key code; holds between presses.
- `key_valid`  output  1  one-cycle pulse when `key` takes a new accepted code.
- `key_held`  output  1  high while an accepted key remains pressed.

## Operation
- Keymap (row, col) → code:
  - row0: 1, 2, 3
  - row1: 4, 5, 6
  - row2: 7, 8, 9
  - row3: `*`=4'hA, 0=4'h0, `#`=4'hB
  - `KEY_NONE`=4'hF.
- `col_n` passes through a 2-flop synchroniser (`col_s`). All decisions use `col_s` only.
- **SCAN**
  - Rows rotate 0→1→2→3→0; each row is driven for `SCAN_DIV` cycles.
  - Sampling happens on the last dwell cycle only.
  - Exactly one column low: capture row/column, go to DEBOUNCE, freeze `row_n`.
  - Zero columns low, or more than one low (ghost/multi-press): advance to the next row.
- **DEBOUNCE**
  - Counter increments each cycle `col_s` equals the captured pattern.
  - Any mismatch: back to SCAN at the next row, no output.
  - Counter reaching `DEBOUNCE_CYCLES`:
    - `key` ← code and `key_valid`=1 on the same edge;
    - `key_held`=1;
    - go to PRESSED.
- **PRESSED**
  - `row_n` stays frozen.
  - Release counter increments while `col_s`=3'b111 and clears on any low column.
  - Reaching `DEBOUNCE_CYCLES`: `key_held`=0, go to SCAN at row 0 with a fresh dwell.
  - Other keys pressed while in PRESSED are ignored; no auto-repeat.
- `key` never changes except together with `key_valid`.

## Timing
- Reset values (cycle after `reset` sampled high):
  - state SCAN, row 0, dwell counter 0;
  - `row_n`=4'b1110, `key`=4'hF, `key_valid`=0, `key_held`=0;
  - synchroniser flops = 3'b111, debounce counters 0.
- Reset mid-operation (any state): same values, no `key_valid` pulse. A key still held is detected afresh as a new press.
- Pin-to-`col_s` latency: 2 cycles.
- If the SCAN sample that detects a press is at cycle T, `key_valid` is high in cycle T+`DEBOUNCE_CYCLES`, assuming a stable pin.
- `key_valid` is never high on two consecutive cycles. Minimum spacing between pulses is `2*DEBOUNCE_CYCLES+1` cycles.
- If the press happens mid-dwell, detection waits for that row's last dwell cycle. Worst case to detection is `4*SCAN_DIV+2` cycles.
- Dwell counter wraps `SCAN_DIV-1`→0 and row index wraps 3→0; the dwell counter does not advance outside SCAN.

## Structure
- Package `keypad_pkg` holds:
  - state enum {SCAN, DEBOUNCE, PRESSED};
  - `KEY_STAR`, `KEY_HASH`, `KEY_NONE` constants;
  - the row/column → code mapping function.
- Sub-module `col_sync`: parameterised-width 2-flop synchroniser with synchronous reset to all-ones.
- Counter widths are derived with `$clog2` from the parameters.

## Test plan
All scenarios use `SCAN_DIV`=4 and `DEBOUNCE_CYCLES`=3.
- **Reset and scan.** Assert `reset` 2 cycles with `col_n`=3'b111. Required:
  - `row_n` sequence 1110, 1101, 1011, 0111, each for exactly 4 cycles, repeating;
  - `key`=4'hF; `key_valid`=0; `key_held`=0.
- **Clean press of '5'.** Drive `col_n`=3'b101 whenever `row_n`=1101 and hold ≥20 cycles, then release. Required:
  - exactly one `key_valid` pulse with `key`=4'h5;
  - `row_n` frozen at 1101 while held;
  - `key_held` falls 3 cycles after `col_s` returns high, and scanning restarts at 1110.
- **Bounce rejection.** Drive `col_n`=3'b011 on row 0 for 2 `col_s` cycles, then release. Required: no `key_valid`, `key` stays 4'hF, scanning continues at row 1.
- **Multi-column rejection.** Drive `col_n`=3'b001 on row 2. Required: no `key_valid`, rows keep rotating.
- **Code sequence.** Press 3, 3, 5, 2, 5, 6 with clean releases. Required: six pulses carrying 4'h3, 4'h3, 4'h5, 4'h2, 4'h5, 4'h6 in order. Also press `#` (row3/col2) and require `key`=4'hB.
- **Reset mid-press.** Assert `reset` 1 cycle during PRESSED on '8' with the key still held. Required:
  - outputs return to reset values with no pulse;
  - '8' then yields a new `key_valid` with `key`=4'h8.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types, key codes and the row/column to key-code mapping for the
// 4x3 matrix keypad scanner.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      PRESSED
   } state_t;

   localparam logic [3:0] KEY_STAR = 4'hA;
   localparam logic [3:0] KEY_HASH = 4'hB;
   localparam logic [3:0] KEY_NONE = 4'hF;

   function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      if (row == 2'd3) begin
         case (col)
            2'd0:    code = KEY_STAR;
            2'd1:    code = 4'h0;
            default: code = KEY_HASH;
         endcase
      end else begin
         code = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
      end
      return code;
   endfunction

   // True when exactly one of the three active-low columns is asserted.
   function automatic logic single_low(input logic [2:0] c);
      return (c == 3'b110) || (c == 3'b101) || (c == 3'b011);
   endfunction

   function automatic logic [1:0] low_index(input logic [2:0] c);
      logic [1:0] idx;
      case (c)
         3'b110:  idx = 2'd0;
         3'b101:  idx = 2'd1;
         default: idx = 2'd2;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/col_sync.sv
// Two-flop synchroniser for asynchronous active-low inputs; resets to the
// idle (all-ones) level so no phantom press is seen after reset.
module col_sync #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_reg;
   logic [WIDTH-1:0] sync_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_reg <= '1;
         sync_reg <= '1;
      end else begin
         meta_reg <= d;
         sync_reg <= meta_reg;
      end
   end

   assign q = sync_reg;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner: rotates row drive, debounces a single-column press,
// emits one key_valid strobe per press and waits for a debounced release.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV        = 8,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] col_n,
   output logic [3:0] row_n,
   output logic [3:0] key,
   output logic       key_valid,
   output logic       key_held
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

   logic [2:0]    col_s;
   state_t        state_reg, state_next;
   logic [1:0]    row_reg, row_next;
   logic [DW-1:0] dwell_reg, dwell_next;
   logic [CW-1:0] deb_reg, deb_next;
   logic [2:0]    pat_reg, pat_next;
   logic [3:0]    code_reg, code_next;
   logic [3:0]    key_reg, key_next;
   logic          key_valid_reg, key_valid_next;
   logic          key_held_reg, key_held_next;

   col_sync #(.WIDTH(3)) u_col_sync (
      .clk   (clk),
      .reset (reset),
      .d     (col_n),
      .q     (col_s)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= SCAN;
         row_reg       <= 2'd0;
         dwell_reg     <= '0;
         deb_reg       <= '0;
         pat_reg       <= 3'b111;
         code_reg      <= KEY_NONE;
         key_reg       <= KEY_NONE;
         key_valid_reg <= 1'b0;
         key_held_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         row_reg       <= row_next;
         dwell_reg     <= dwell_next;
         deb_reg       <= deb_next;
         pat_reg       <= pat_next;
         code_reg      <= code_next;
         key_reg       <= key_next;
         key_valid_reg <= key_valid_next;
         key_held_reg  <= key_held_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      row_next       = row_reg;
      dwell_next     = dwell_reg;
      deb_next       = deb_reg;
      pat_next       = pat_reg;
      code_next      = code_reg;
      key_next       = key_reg;
      key_valid_next = 1'b0;
      key_held_next  = key_held_reg;

      case (state_reg)
         SCAN: begin
            if (dwell_reg == DWELL_LAST) begin
               dwell_next = '0;
               if (single_low(col_s)) begin
                  pat_next  = col_s;
                  code_next = key_code(row_reg, low_index(col_s));
                  // The sampling cycle itself counts as the first stable cycle.
                  if (DEBOUNCE_CYCLES == 1) begin
                     key_next       = key_code(row_reg, low_index(col_s));
                     key_valid_next = 1'b1;
                     key_held_next  = 1'b1;
                     deb_next       = '0;
                     state_next     = PRESSED;
                  end else begin
                     deb_next   = CW'(1);
                     state_next = DEBOUNCE;
                  end
               end else begin
                  row_next = row_reg + 2'd1;
               end
            end else begin
               dwell_next = dwell_reg + DW'(1);
            end
         end

         DEBOUNCE: begin
            if (col_s == pat_reg) begin
               if (deb_reg == DEB_LAST) begin
                  key_next       = code_reg;
                  key_valid_next = 1'b1;
                  key_held_next  = 1'b1;
                  deb_next       = '0;
                  state_next     = PRESSED;
               end else begin
                  deb_next = deb_reg + CW'(1);
               end
            end else begin
               deb_next   = '0;
               row_next   = row_reg + 2'd1;
               dwell_next = '0;
               state_next = SCAN;
            end
         end

         PRESSED: begin
            if (col_s == 3'b111) begin
               if (deb_reg == DEB_LAST) begin
                  key_held_next = 1'b0;
                  deb_next      = '0;
                  row_next      = 2'd0;
                  dwell_next    = '0;
                  state_next    = SCAN;
               end else begin
                  deb_next = deb_reg + CW'(1);
               end
            end else begin
               deb_next = '0;
            end
         end

         default: begin
            state_next = SCAN;
            row_next   = 2'd0;
            dwell_next = '0;
            deb_next   = '0;
         end
      endcase
   end

   assign row_n     = ~(4'b0001 << row_reg);
   assign key       = key_reg;
   assign key_valid = key_valid_reg;
   assign key_held  = key_held_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomised bench for keypad_scanner: a physical keypad model drives col_n
// from row_n and expectations come from the keymap and latency arithmetic.
module tb_keypad_scanner;

   localparam int SCAN_DIV = 4;
   localparam int DEB      = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] col_n;
   logic [3:0] row_n;
   logic [3:0] key;
   logic       key_valid;
   logic       key_held;

   // Physical keypad: a pattern on one row, plus a raw override for bounce tests.
   int         phys_row = 0;
   logic [2:0] phys_pat = 3'b111;
   logic       phys_on = 1'b0;
   logic       override_on = 1'b0;
   logic [2:0] override_val = 3'b111;

   int   checks = 0;
   int   errors = 0;
   int   pulses = 0;
   int   exp_pulses = 0;
   logic [3:0] exp_key = 4'hF;
   logic prev_valid = 1'b0;

   always #5 clk = ~clk;

   keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
      .clk       (clk),
      .reset     (reset),
      .col_n     (col_n),
      .row_n     (row_n),
      .key       (key),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   function automatic logic [3:0] row_sel(input int r);
      logic [3:0] one;
      one = 4'b0001;
      return ~(one << r);
   endfunction

   function automatic int ref_code(input int r, input int c);
      if (r < 3) return r * 3 + c + 1;
      if (c == 0) return 10;
      if (c == 1) return 0;
      return 11;
   endfunction

   always_comb begin
      if (override_on)
         col_n = override_val;
      else if (phys_on && row_n == row_sel(phys_row))
         col_n = phys_pat;
      else
         col_n = 3'b111;
   end

   task automatic check(input string tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      check("row_onehot", $countones(~row_n), 1);
      if (prev_valid) check("valid_gap", key_valid, 0);
      if (key_valid) pulses++;
      else check("key_stable", key, exp_key);
      prev_valid = key_valid;
   endtask

   // Wait for a fresh dwell on row r (bounded); leaves the bench at its first cycle.
   task automatic wait_row_start(input int r, input logic press, input int c);
      int n;
      n = 0;
      while (row_n == row_sel(r) && n < 40) begin tick(); n++; end
      if (press) begin
         phys_row = r;
         phys_pat = ~(3'b001 << c);
         phys_on  = 1'b1;
      end
      n = 0;
      while (row_n != row_sel(r) && n < 40) begin tick(); n++; end
      check("row_reach", int'(n < 40), 1);
   endtask

   task automatic detect_key(input int r, input int c);
      int n;
      wait_row_start(r, 1'b1, c);
      n = 0;
      while (!key_valid && n < 40) begin tick(); n++; end
      check("valid_latency", n, SCAN_DIV - 1 + DEB);
      check("key_code", key, ref_code(r, c));
      check("held_on_accept", key_held, 1);
      exp_key = 4'(ref_code(r, c));
      exp_pulses++;
      $display("press row %0d col %0d -> key %0h after %0d cycles", r, c, key, n);
   endtask

   task automatic hold_release(input int r, input int hold);
      int n;
      for (int i = 0; i < hold; i++) begin
         tick();
         check("row_frozen", row_n, row_sel(r));
         check("held_high", key_held, 1);
      end
      phys_on = 1'b0;
      n = 0;
      while (key_held && n < 40) begin tick(); n++; end
      check("release_latency", n, 2 + DEB);
      check("scan_restart", row_n, 4'b1110);
   endtask

   initial begin
      int n;
      int seq_r[7] = '{0, 0, 1, 0, 1, 1, 3};
      int seq_c[7] = '{2, 2, 1, 1, 1, 2, 2};

      // Reset and idle scan
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      check("rst_row", row_n, 4'b1110);
      check("rst_key", key, 4'hF);
      check("rst_valid", key_valid, 0);
      check("rst_held", key_held, 0);
      for (int i = 1; i < 32; i++) begin
         tick();
         check("idle_row", row_n, row_sel((i / SCAN_DIV) % 4));
         check("idle_held", key_held, 0);
      end

      // Clean press of '5'
      detect_key(1, 1);
      hold_release(1, 20);

      // Bounce on row 0: col_s low only on the sample cycle and the next one
      wait_row_start(0, 1'b0, 0);
      tick();
      override_val = 3'b011;
      override_on  = 1'b1;
      tick();
      tick();
      override_on = 1'b0;
      tick();
      tick();
      check("bounce_frozen", row_n, 4'b1110);
      tick();
      check("bounce_next_row", row_n, 4'b1101);
      check("bounce_held", key_held, 0);
      for (int i = 0; i < 20; i++) tick();

      // Two columns low on row 2
      phys_row = 2;
      phys_pat = 3'b001;
      phys_on  = 1'b1;
      wait_row_start(2, 1'b0, 0);
      for (int i = 0; i < SCAN_DIV; i++) tick();
      check("multi_rotate", row_n, 4'b0111);
      for (int i = 0; i < 16; i++) tick();
      phys_on = 1'b0;
      check("multi_held", key_held, 0);
      for (int i = 0; i < 4; i++) tick();

      // Code sequence 3,3,5,2,5,6 then '#'
      for (int k = 0; k < 7; k++) begin
         detect_key(seq_r[k], seq_c[k]);
         hold_release(seq_r[k], int'($urandom_range(1, 12)));
         n = int'($urandom_range(0, 9));
         for (int i = 0; i < n; i++) tick();
      end
      check("hash_key", key, 4'hB);

      // Random presses
      for (int k = 0; k < 10; k++) begin
         int r;
         int c;
         r = int'($urandom_range(0, 3));
         c = int'($urandom_range(0, 2));
         detect_key(r, c);
         hold_release(r, int'($urandom_range(1, 15)));
         n = int'($urandom_range(0, 9));
         for (int i = 0; i < n; i++) tick();
      end

      // Reset while '8' is held, then the same key is accepted afresh
      detect_key(2, 1);
      for (int i = 0; i < 5; i++) tick();
      reset   = 1'b1;
      exp_key = 4'hF;
      tick();
      reset = 1'b0;
      check("midrst_row", row_n, 4'b1110);
      check("midrst_key", key, 4'hF);
      check("midrst_valid", key_valid, 0);
      check("midrst_held", key_held, 0);
      detect_key(2, 1);
      hold_release(2, 6);
      for (int i = 0; i < 10; i++) tick();

      check("pulse_count", pulses, exp_pulses);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
